// File: rtl/gcm_pkg.sv
// Shared widths, data types and feeder FSM states for the AES-GCM front end.
package gcm_pkg;
  localparam int BLK_W = 128;
  localparam int IV_W  = 96;
  localparam int LEN_W = 64;

  typedef logic [BLK_W-1:0] block_t;
  typedef logic [BLK_W-1:0] key_t;
  typedef logic [IV_W-1:0]  iv_t;
  typedef logic [LEN_W-1:0] len_t;

  typedef enum logic [1:0] {IDLE, FILL, STREAM} feeder_state_e;
endpackage

// File: rtl/gcm_blk_fifo.sv
// Synchronous block FIFO. Head is visible combinationally, and a pop or push takes effect on the next edge.
// A push while full and a pop while empty are ignored, so the caller may request blindly.
module gcm_blk_fifo
  import gcm_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  block_t                 push_data,
  input  logic                   pop,
  output block_t                 head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  block_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/gcm_block_feeder.sv
// Buffers AAD/PT blocks and launches each descriptor into stage 1 as one gap-free burst. Issue is registered:
// a block popped in cycle N appears in cycle N+1. Blocks are backpressured only when the FIFO is full.
module gcm_block_feeder
  import gcm_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 32
) (
  input  logic               clk,
  input  logic               i_rst_n,
  input  logic               i_desc_valid,
  output logic               o_desc_ready,
  input  logic [BLK_W-1:0]   i_desc_key,
  input  logic [IV_W-1:0]    i_desc_iv,
  input  logic [LEN_W-1:0]   i_desc_pt_bits,
  input  logic [LEN_W-1:0]   i_desc_aad_bits,
  input  logic               i_blk_valid,
  output logic               o_blk_ready,
  input  logic [BLK_W-1:0]   i_blk_data,
  output logic [BLK_W-1:0]   o_cipher_key,
  output logic [IV_W-1:0]    o_iv,
  output logic [2*LEN_W-1:0] o_instance_size,
  output logic [BLK_W-1:0]   o_aad,
  output logic [BLK_W-1:0]   o_plain_text,
  output logic               o_new_instance,
  output logic               o_pt_instance,
  output logic               o_busy,
  output logic               o_desc_err,
  output logic               o_underrun
);
  localparam int FC_W = $clog2(FIFO_DEPTH) + 1;

  feeder_state_e    state;
  logic             live;
  logic [CNT_W-1:0] tot_blks;
  logic [CNT_W-1:0] aad_blks;
  logic [CNT_W-1:0] issued;
  logic [CNT_W-1:0] fill_thr;
  block_t           head;
  logic             full;
  logic             empty;
  logic [FC_W-1:0]  fifo_count;
  logic             push;
  logic             pop;
  logic             desc_fire;
  logic             desc_bad;
  logic [LEN_W:0]   sum_bits;
  logic [LEN_W-7:0] sum_blks;

  // Ready stays low until the first clock after reset release, so every output reads 0 during reset.
  assign o_desc_ready = live & (state == IDLE);
  assign o_blk_ready  = live & ~full;
  assign o_busy       = (state != IDLE);
  assign push         = i_blk_valid & o_blk_ready;
  assign pop          = (state == STREAM);
  assign desc_fire    = i_desc_valid & o_desc_ready;

  assign sum_bits = {1'b0, i_desc_aad_bits} + {1'b0, i_desc_pt_bits};
  assign sum_blks = sum_bits[LEN_W:7];
  assign desc_bad = (i_desc_aad_bits[6:0] != '0) | (i_desc_pt_bits[6:0] != '0) |
                    (sum_bits == '0) | ((sum_blks >> CNT_W) != '0);
  assign fill_thr = (tot_blks < CNT_W'(FIFO_DEPTH)) ? tot_blks : CNT_W'(FIFO_DEPTH);

  gcm_blk_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (i_rst_n),
    .push      (push),
    .push_data (i_blk_data),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state           <= IDLE;
      live            <= 1'b0;
      tot_blks        <= '0;
      aad_blks        <= '0;
      issued          <= '0;
      o_cipher_key    <= '0;
      o_iv            <= '0;
      o_instance_size <= '0;
      o_aad           <= '0;
      o_plain_text    <= '0;
      o_new_instance  <= 1'b0;
      o_pt_instance   <= 1'b0;
      o_desc_err      <= 1'b0;
      o_underrun      <= 1'b0;
    end else begin
      live           <= 1'b1;
      o_desc_err     <= 1'b0;
      o_aad          <= '0;
      o_plain_text   <= '0;
      o_new_instance <= 1'b0;
      o_pt_instance  <= 1'b0;
      case (state)
        IDLE: begin
          if (desc_fire) begin
            if (desc_bad) begin
              o_desc_err <= 1'b1;
            end else begin
              o_cipher_key    <= i_desc_key;
              o_iv            <= i_desc_iv;
              o_instance_size <= {i_desc_pt_bits, i_desc_aad_bits};
              aad_blks        <= CNT_W'(i_desc_aad_bits >> 7);
              tot_blks        <= CNT_W'(sum_blks);
              issued          <= '0;
              state           <= FILL;
            end
          end
        end
        FILL: begin
          if (CNT_W'(fifo_count) >= fill_thr) state <= STREAM;
        end
        STREAM: begin
          // An empty FIFO still consumes a slot: stage 1 counts cycles, so a zero block keeps it aligned.
          o_new_instance <= (issued == '0);
          if (issued < aad_blks) begin
            o_aad <= empty ? '0 : head;
          end else begin
            o_plain_text  <= empty ? '0 : head;
            o_pt_instance <= 1'b1;
          end
          if (empty) o_underrun <= 1'b1;
          issued <= issued + 1'b1;
          if (issued == tot_blks - 1'b1) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
